cfg_spi_sched: RTL and testbench

//   Queues configuration words from the UART command decoder and writes each one to its target device.

---
 rtl/cfg_spi_sched.sv | 216 +++++++++++++++++++++
 tb/tb_cfg_spi_sched.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_spi_sched.sv
// cfg_spi_sched: queues configuration words and writes each one
// to its target device as a 32-bit SPI frame followed by io_update.
module cfg_spi_sched #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int UPD_LEN    = 10,
  parameter int GAP        = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        trig,
  input  logic [1:0]  Adress,
  input  logic [5:0]  Mod_SEL,
  input  logic [23:0] D,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic [2:0]  spi_cs_n,
  output logic        io_update,
  output logic        busy,
  output logic        overflow,
  output logic        addr_err
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CMAX_A = (2 * CLK_DIV > UPD_LEN) ? 2 * CLK_DIV : UPD_LEN;
  localparam int CMAX   = (CMAX_A > GAP) ? CMAX_A : GAP;
  localparam int CW     = $clog2(CMAX + 1);

  localparam logic [CW-1:0] CD_M1  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BIT_M1 = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] UPD_M1 = CW'(UPD_LEN - 1);
  localparam logic [CW-1:0] GAP_M1 = CW'(GAP - 1);
  localparam logic [AW:0]   FULL_N = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_HOLD,
    S_UPDATE,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   sr_q, sr_d;
  logic [4:0]    bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic [2:0]    cs_n_q, cs_n_d;
  logic          upd_q, upd_d;
  logic          ovf_q, ovf_d;
  logic          aerr_q, aerr_d;

  logic        full;
  logic        empty;
  logic        pop;
  logic        push;
  logic        legal;
  logic [31:0] head;
  logic [31:0] wdata;

  function automatic logic [2:0] cs_sel(input logic [1:0] a);
    logic [2:0] r;
    unique case (a)
      2'd0:    r = 3'b110;
      2'd1:    r = 3'b101;
      default: r = 3'b011;
    endcase
    return r;
  endfunction

  assign full  = (count_q == FULL_N);
  assign empty = (count_q == '0);
  assign pop   = (state_q == S_LOAD);
  assign legal = (Adress != 2'd3);
  assign push  = trig && legal && (!full || pop);
  assign head  = mem_q[rd_ptr_q];
  assign wdata = {Mod_SEL, Adress, D};

  // Queue bookkeeping and sticky error flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    aerr_d   = aerr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (trig && legal && full && !pop) ovf_d = 1'b1;
    if (trig && !legal) aerr_d = 1'b1;
  end

  // Frame sequencer: next state and registered pin values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    upd_d   = upd_q;
    unique case (state_q)
      S_IDLE: begin
        if (!empty || push) state_d = S_LOAD;
      end
      S_LOAD: begin
        sr_d    = head;
        bit_d   = 5'd31;
        cnt_d   = '0;
        sclk_d  = 1'b0;
        mosi_d  = head[31];
        cs_n_d  = cs_sel(head[25:24]);
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CD_M1) sclk_d = 1'b1;
        if (cnt_q == BIT_M1) begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          if (bit_q == 5'd0) begin
            mosi_d  = 1'b0;
            state_d = S_HOLD;
          end else begin
            bit_d  = bit_q - 5'd1;
            sr_d   = {sr_q[30:0], 1'b0};
            mosi_d = sr_q[30];
          end
        end
      end
      S_HOLD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CD_M1) begin
          cnt_d   = '0;
          cs_n_d  = 3'b111;
          upd_d   = 1'b1;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == UPD_M1) begin
          cnt_d   = '0;
          upd_d   = 1'b0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == GAP_M1) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Queue storage; emptiness is tracked by count, so no reset needed.
  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  // State and control registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sr_q     <= '0;
      bit_q    <= '0;
      cnt_q    <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      cs_n_q   <= 3'b111;
      upd_q    <= 1'b0;
      ovf_q    <= 1'b0;
      aerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sr_q     <= sr_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      cs_n_q   <= cs_n_d;
      upd_q    <= upd_d;
      ovf_q    <= ovf_d;
      aerr_q   <= aerr_d;
    end
  end

  assign spi_sclk  = sclk_q;
  assign spi_mosi  = mosi_q;
  assign spi_cs_n  = cs_n_q;
  assign io_update = upd_q;
  assign overflow  = ovf_q;
  assign addr_err  = aerr_q;
  assign busy      = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_cfg_spi_sched.sv
// tb_cfg_spi_sched: randomized scoreboard bench for cfg_spi_sched
// against a timeline-level reference of queue acceptance and frames.
module tb_cfg_spi_sched;

  localparam int CD    = 4;
  localparam int DEPTH = 4;
  localparam int UPD   = 10;
  localparam int GP    = 8;
  localparam int FRAME = 1 + 65 * CD + UPD + GP;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        trig = 1'b0;
  logic [1:0]  adr = '0;
  logic [5:0]  mods = '0;
  logic [23:0] d = '0;
  logic        spi_sclk, spi_mosi, io_update, busy, overflow, addr_err;
  logic [2:0]  spi_cs_n;

  cfg_spi_sched #(
    .CLK_DIV(CD), .FIFO_DEPTH(DEPTH), .UPD_LEN(UPD), .GAP(GP)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .trig(trig),
    .Adress(adr), .Mod_SEL(mods), .D(d),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .io_update(io_update), .busy(busy),
    .overflow(overflow), .addr_err(addr_err)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] word;
    int          fall;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mq[$];
  int          idle_at = 0;
  int          load_at = 0;
  bit          load_pending = 0;
  bit          exp_ovf = 0;
  bit          exp_aerr = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [2:0] cs_of(input logic [1:0] a);
    if (a == 2'd0) return 3'b110;
    if (a == 2'd1) return 3'b101;
    return 3'b011;
  endfunction

  task automatic model_reset();
    mq.delete();
    sb.delete();
    idle_at = 0;
    load_pending = 0;
    exp_ovf = 0;
    exp_aerr = 0;
  endtask

  // One sys_clk cycle of stimulus plus the reference timeline.
  task automatic step(input bit t, input logic [1:0] a,
                      input logic [5:0] m, input logic [23:0] dd);
    int c;
    exp_t e;
    c = cyc;
    trig = t;
    adr = a;
    mods = m;
    d = dd;
    if (load_pending && c == load_at) begin
      e.word = mq.pop_front();
      e.fall = c + 1;
      sb.push_back(e);
      idle_at = c + FRAME;
      load_pending = 0;
    end
    if (t) begin
      if (a == 2'd3) exp_aerr = 1;
      else if (mq.size() < DEPTH) mq.push_back({m, a, dd});
      else exp_ovf = 1;
    end
    if (!load_pending && c >= idle_at && mq.size() > 0) begin
      load_pending = 1;
      load_at = c + 1;
    end
    @(posedge sys_clk);
    #1;
    trig = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 2'd0, 6'd0, 24'd0);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((mq.size() > 0 || load_pending || cyc < idle_at ||
            sb.size() > 0 || busy || io_update) && n < 5000) begin
      step(0, 2'd0, 6'd0, 24'd0);
      n++;
    end
    chk({name, "_timeout"}, 64'(n >= 5000), 64'd0);
    chk({name, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic check_flags(input string name);
    chk({name, "_overflow"}, 64'(overflow), 64'(exp_ovf));
    chk({name, "_addr_err"}, 64'(addr_err), 64'(exp_aerr));
  endtask

  // Monitor: SPI slave capture and io_update timing.
  bit          in_frame = 0;
  bit          viol = 0;
  bit          prev_sclk = 0;
  bit          prev_upd = 0;
  int          fall_c = 0;
  int          first_rise = -1;
  int          bits = 0;
  int          last_rise_c = 0;
  int          upd_start = 0;
  logic [31:0] mw = '0;
  logic [2:0]  mcs = 3'b111;

  task automatic frame_end(input int c);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame: got word 0x%0h cs %b want none",
               mw, mcs);
    end else begin
      e = sb.pop_front();
      chk("frame_word", 64'(mw), 64'(e.word));
      chk("frame_cs", 64'(mcs), 64'(cs_of(e.word[25:24])));
      chk("frame_bits", 64'(bits), 64'd32);
      chk("cs_fall_cycle", 64'(fall_c), 64'(e.fall));
      chk("first_rise_ofs", 64'(first_rise - fall_c), 64'(CD));
      chk("cs_low_len", 64'(c - fall_c), 64'(65 * CD));
      chk("frame_pin_rules", 64'(viol), 64'd0);
    end
    viol = 0;
    last_rise_c = c;
  endtask

  always @(negedge sys_clk) begin
    if (sys_rst) begin
      in_frame = 0;
      prev_sclk = 0;
      prev_upd = 0;
      viol = 0;
    end else begin
      if ($countones(~spi_cs_n) > 1) viol = 1;
      if (spi_sclk && spi_cs_n == 3'b111) viol = 1;
      if (!in_frame && spi_cs_n != 3'b111) begin
        in_frame = 1;
        fall_c = cyc;
        mcs = spi_cs_n;
        bits = 0;
        mw = '0;
        first_rise = -1;
      end else if (in_frame && spi_cs_n == 3'b111) begin
        in_frame = 0;
        frame_end(cyc);
      end
      if (in_frame) begin
        if (spi_cs_n != mcs) viol = 1;
        if (spi_sclk && !prev_sclk) begin
          mw = {mw[30:0], spi_mosi};
          bits++;
          if (first_rise < 0) first_rise = cyc;
        end
      end
      if (io_update && !prev_upd) begin
        upd_start = cyc;
        chk("upd_start", 64'(cyc), 64'(last_rise_c));
      end
      if (!io_update && prev_upd)
        chk("upd_len", 64'(cyc - upd_start), 64'(UPD));
      prev_sclk = spi_sclk;
      prev_upd = io_update;
    end
  end

  task automatic check_reset_pins(input string name);
    chk({name, "_cs_n"}, 64'(spi_cs_n), 64'(3'b111));
    chk({name, "_sclk"}, 64'(spi_sclk), 64'd0);
    chk({name, "_mosi"}, 64'(spi_mosi), 64'd0);
    chk({name, "_io_update"}, 64'(io_update), 64'd0);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_overflow"}, 64'(overflow), 64'd0);
    chk({name, "_addr_err"}, 64'(addr_err), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int t0;
    int n;
    repeat (3) @(posedge sys_clk);
    #1;
    check_reset_pins("reset");
    sys_rst = 1'b0;
    model_reset();

    // Single write on device 0.
    step(1, 2'd0, 6'h01, 24'h123456);
    drain("single");
    chk("single_word_const", 64'(mw), 64'h04123456);
    check_flags("single");

    // Illegal address, then a legal write to device 2.
    step(1, 2'd3, 6'h2a, 24'hdeadbe);
    idle(5);
    chk("illegal_no_frame", 64'(spi_cs_n), 64'(3'b111));
    step(1, 2'd2, 6'h15, 24'h00beef);
    drain("illegal");
    check_flags("illegal");

    // Fill the queue behind a frame, then push exactly at LOAD.
    for (int i = 0; i < 5; i++)
      step(1, 2'd2, 6'(i), 24'(32'h100 + i));
    n = 0;
    while (!(load_pending && cyc == load_at) && n < 2000) begin
      step(0, 2'd0, 6'd0, 24'd0);
      n++;
    end
    chk("fullpop_wait", 64'(n >= 2000), 64'd0);
    step(1, 2'd0, 6'h3f, 24'hf0f0f0);
    drain("fullpop");
    check_flags("fullpop");

    // Burst of six on device 1: sixth is dropped.
    for (int i = 0; i < 6; i++)
      step(1, 2'd1, 6'(i + 8), 24'(32'habc000 + i));
    drain("burst");
    check_flags("burst");

    // Ten spaced commands wrap the queue pointers.
    for (int i = 1; i <= 10; i++) begin
      step(1, 2'(i % 3), 6'h05, 24'(i));
      idle(FRAME + 10);
    end
    drain("wrap");

    // Randomized traffic with mixed spacing and addresses.
    for (int i = 0; i < 40; i++) begin
      step(1, 2'($urandom_range(0, 3)), 6'($urandom()),
           24'($urandom()));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(100, 400));
      else idle($urandom_range(0, 3));
    end
    drain("random");
    check_flags("random");

    // Asynchronous reset inside bit 15 of a frame.
    step(1, 2'd0, 6'h11, 24'h5a5a5a);
    t0 = cyc - 1;
    while (cyc < t0 + 2 + 32 * CD + 2) step(0, 2'd0, 6'd0, 24'd0);
    chk("pre_reset_cs", 64'(spi_cs_n), 64'(3'b110));
    #2;
    sys_rst = 1'b1;
    #1;
    check_reset_pins("midrst");
    model_reset();
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    idle(FRAME + 20);
    chk("post_rst_cs", 64'(spi_cs_n), 64'(3'b111));
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_sb", 64'(sb.size()), 64'd0);
    check_flags("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
